// File: rtl/shift_right_iter_32.sv
// Iterative 32-bit right shifter: one bit position per clock in SHIFT, with
// rotate, logical and arithmetic fill. The result is published to out on DONE entry.
module shift_right_iter_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [4:0]  amt,
  input  logic [1:0]  mode,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOGICAL    = 2'b01;
  localparam logic [1:0] MODE_ARITHMETIC = 2'b10;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  cnt;
  logic [1:0]  cmode;
  logic        fill;
  logic [31:0] shifted;

  // Next working value: one-bit move right, bit 31 filled from the captured mode.
  // Mode 11 falls through to the rotate fill.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fill = work[0];
    unique case (cmode)
      MODE_LOGICAL:    fill = 1'b0;
      MODE_ARITHMETIC: fill = work[31];
      default:         fill = work[0];
    endcase
    shifted = {fill, work[31:1]};
  end

  // NOTE: busy/done are registered alongside the state so they change on the
  // same edge as the state they describe and can never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      cmode <= 2'b00;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            work  <= a;
            cnt   <= amt;
            cmode <= mode;
            if (amt != 5'd0) begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              out   <= a;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        SHIFT: begin
          work <= shifted;
          // The last shift still happens on the cycle the counter reads 1.
          if (cnt <= 5'd1) begin
            cnt   <= 5'd0;
            state <= DONE;
            out   <= shifted;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_right_iter_32.md
SHIFT_RIGHT_ITER_32 -- requirements
Module: shift_right_iter_32

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE or DONE
- a  input  32  operand captured on accepted start
- amt  input  5  shift count 0..31, captured on accepted start
- mode  input  2  00 rotate right, 01 logical right, 10 arithmetic right, 11 treated as 00
- out  output  32  result register
- busy  output  1  high while state is SHIFT
- done  output  1  one-cycle pulse, high while state is DONE

Function
REQ-003 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-004 The datapath SHALL hold a 32-bit working register, a 5-bit down-counter and a 2-bit captured mode.
REQ-005 A start accepted in IDLE or DONE at edge T SHALL load the working register with a, the counter with amt and the captured mode with mode.
REQ-006 On that accept, the next state SHALL be SHIFT if amt != 0, else DONE.
REQ-007 start SHALL be ignored while in SHIFT; captured operands SHALL NOT change mid-operation.
REQ-008 Each SHIFT cycle SHALL move the working register right by exactly one bit position.
REQ-009 The vacated bit 31 SHALL be filled per captured mode:
- rotate: old bit 0
- logical: 0
- arithmetic: old bit 31
REQ-010 Bit 0 SHALL be discarded for logical and arithmetic modes.
REQ-011 Each SHIFT cycle SHALL decrement the counter by 1.
REQ-012 When the counter equals 1 in SHIFT, the shift SHALL still occur and the next state SHALL be DONE.
REQ-013 For amt = k >= 1, state SHALL be SHIFT for cycles T+1..T+k and DONE at cycle T+k+1.
REQ-014 For amt = 0, state SHALL be DONE at cycle T+1.
REQ-015 out SHALL update only on the edge entering DONE, loading the final working-register value (a itself when amt = 0).
REQ-016 out SHALL hold its value through IDLE and during subsequent SHIFT cycles until the next DONE entry.
REQ-017 From DONE, the next state SHALL be IDLE if start is low; if start is high it SHALL accept the new operation per REQ-005/006 (back-to-back, no idle bubble).
REQ-018 busy and done SHALL be mutually exclusive and SHALL never both be high.
REQ-019 Counter arithmetic SHALL be 5-bit unsigned with no wrap: the counter never decrements below 1 in SHIFT.
REQ-020 mode 11 SHALL produce results identical to mode 00.

Reset
REQ-021 reset high at a clock edge SHALL force state to IDLE, out to 32'h0, busy to 0, done to 0, working register to 0, counter to 0 and captured mode to 00.
REQ-022 reset SHALL take priority over start and over any in-progress SHIFT; an aborted operation SHALL NOT update out.
REQ-023 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-024 Rotate: a=32'h80000001, amt=1, mode=00, start at T -> busy at T+1, done at T+2, out=32'hC0000000.
REQ-025 Logical/arithmetic: a=32'hF0000000, amt=4, mode=01 -> done at T+5, out=32'h0F000000; same with mode=10 -> out=32'hFF000000.
REQ-026 Boundary counts: a=32'h80000000, amt=31, mode=10 -> done at T+32, out=32'hFFFFFFFF; amt=0, a=32'h12345678 -> done at T+1, out=32'h12345678, busy never high.
REQ-027 Start while busy: during amt=8 operation, pulse start with a=32'hFFFFFFFF at T+3 -> ignored, result reflects original operands only, done at T+9.
REQ-028 Reset mid-operation: after a completed result out=32'hC0000000, start amt=10, assert reset at T+5 -> busy=0, done=0, out=32'h0 next cycle, no done pulse follows.
REQ-029 Back-to-back: start held high in the DONE cycle -> new operation accepted, busy high the following cycle, out holds prior result until the new DONE.
